// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480 timing, total-size helpers and 12-bit colours.
package vga_pkg;

  localparam int unsigned CNT_W       = 10;
  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned MAX_TOTAL   = 1024;

  localparam int unsigned DEF_CLK_DIV   = 4;
  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_PIPE_DLY  = 1;

  localparam logic [11:0] COLOR_BLACK  = 12'h000;
  localparam logic [11:0] COLOR_WHITE  = 12'hFFF;
  localparam logic [11:0] COLOR_RED    = 12'hF00;
  localparam logic [11:0] COLOR_GREEN  = 12'h0F0;
  localparam logic [11:0] COLOR_BLUE   = 12'h00F;
  localparam logic [11:0] COLOR_YELLOW = 12'hFF0;

  function automatic int unsigned h_total(input int unsigned disp, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return disp + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned disp, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return disp + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Scan-position / sync bundle between the timing generator and its consumers.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic             pixel_tick;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             video_on;
  logic             hsync;
  logic             vsync;
  logic             line_start;
  logic             frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;
`endif

  modport master (
`ifdef VGA_FRAME_CNT_EN
    output frame_cnt,
`endif
    output pixel_tick, x, y, video_on, hsync, vsync, line_start, frame_start
  );

  modport slave (
`ifdef VGA_FRAME_CNT_EN
    input frame_cnt,
`endif
    input pixel_tick, x, y, video_on, hsync, vsync, line_start, frame_start
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// Tick-enabled shift register that delays a sync signal by DEPTH pixel ticks.
// Reset fills every stage with FILL (the inactive sync level).
module sync_delay #(
  parameter int unsigned DEPTH = 1,
  parameter logic        FILL  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= {DEPTH{FILL}};
    end else if (tick) begin
      sr_q <= (sr_q << 1) | DEPTH'(din);
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate tick, h/v counters, video_on, delayed syncs, start pulses.
// Define VGA_FRAME_CNT_EN to add the 16-bit completed-frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter logic        SYNC_POL  = 1'b0,
  parameter int unsigned PIPE_DLY  = DEF_PIPE_DLY
) (
  input logic              sys_clk,
  input logic              sys_rst,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOT     = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOT     = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CMP_W     = CNT_W + 1;
  localparam int unsigned HS_START  = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_STOP   = HS_START + H_SYNC;
  localparam int unsigned VS_START  = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_STOP   = VS_START + V_SYNC;
  localparam int unsigned DLY_DEPTH = (PIPE_DLY == 0) ? 1 : PIPE_DLY;

  if (CLK_DIV == 0 || PIPE_DLY > 7 || H_TOT > MAX_TOTAL || V_TOT > MAX_TOTAL) begin : g_cfg_err
    $error("vga_timing_gen: illegal timing configuration");
  end

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic             tick_q, tick_nxt;
  logic [CNT_W-1:0] h_cnt, h_nxt;
  logic [CNT_W-1:0] v_cnt, v_nxt;
  logic             vid_q, vid_nxt;
  logic             line_q, line_nxt;
  logic             frame_q, frame_nxt;
  logic [CNT_W-1:0] hs_src_c, vs_src_c;
  logic             hs_raw_c, vs_raw_c;
  logic             dly_tick_c;

  // Next-state for divider, raster counters and start pulses
  always_comb begin
    div_nxt   = div_cnt;
    tick_nxt  = 1'b0;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    line_nxt  = 1'b0;
    frame_nxt = 1'b0;

    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_nxt  = '0;
      tick_nxt = 1'b1;
    end else begin
      div_nxt = div_cnt + DIV_W'(1);
    end

    if (tick_q) begin
      if (h_cnt == CNT_W'(H_TOT - 1)) begin
        h_nxt    = '0;
        line_nxt = 1'b1;
        if (v_cnt == CNT_W'(V_TOT - 1)) begin
          v_nxt     = '0;
          frame_nxt = 1'b1;
        end else begin
          v_nxt = v_cnt + CNT_W'(1);
        end
      end else begin
        h_nxt = h_cnt + CNT_W'(1);
      end
    end

    vid_nxt = ({1'b0, h_nxt} < CMP_W'(H_DISPLAY)) && ({1'b0, v_nxt} < CMP_W'(V_DISPLAY));
  end

  // Zero delay samples the upcoming counters so syncs line up with x/y exactly
  always_comb begin
    hs_src_c   = (PIPE_DLY == 0) ? h_nxt : h_cnt;
    vs_src_c   = (PIPE_DLY == 0) ? v_nxt : v_cnt;
    dly_tick_c = (PIPE_DLY == 0) ? 1'b1 : tick_q;
    hs_raw_c   = (({1'b0, hs_src_c} >= CMP_W'(HS_START)) && ({1'b0, hs_src_c} < CMP_W'(HS_STOP)))
                 ? SYNC_POL : ~SYNC_POL;
    vs_raw_c   = (({1'b0, vs_src_c} >= CMP_W'(VS_START)) && ({1'b0, vs_src_c} < CMP_W'(VS_STOP)))
                 ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      vid_q   <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      tick_q  <= tick_nxt;
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      vid_q   <= vid_nxt;
      line_q  <= line_nxt;
      frame_q <= frame_nxt;
    end
  end

  sync_delay #(.DEPTH(DLY_DEPTH), .FILL(~SYNC_POL)) u_hs_dly (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .tick (dly_tick_c),
    .din  (hs_raw_c),
    .dout (vga.hsync)
  );

  sync_delay #(.DEPTH(DLY_DEPTH), .FILL(~SYNC_POL)) u_vs_dly (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .tick (dly_tick_c),
    .din  (vs_raw_c),
    .dout (vga.vsync)
  );

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] fcnt_q;

  // Counts in the same edge that raises frame_start
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fcnt_q <= '0;
    end else if (frame_nxt) begin
      fcnt_q <= fcnt_q + FRAME_CNT_W'(1);
    end
  end

  assign vga.frame_cnt = fcnt_q;
`endif

  assign vga.pixel_tick  = tick_q;
  assign vga.x           = h_cnt;
  assign vga.y           = v_cnt;
  assign vga.video_on    = vid_q;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a cycle-index model pushes expected outputs per edge.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct packed {
    logic        tick;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vid;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   k = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  obs_t q_a[$], q_b[$], q_c[$], q_d[$];

  always #5 sys_clk = ~sys_clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();
  vga_timing_gen_if if_d ();

  vga_timing_gen #(.CLK_DIV(4), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                   .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                   .SYNC_POL(1'b0), .PIPE_DLY(0))
    u_a (.sys_clk(sys_clk), .sys_rst(sys_rst), .vga(if_a));
  vga_timing_gen #(.CLK_DIV(4), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                   .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                   .SYNC_POL(1'b0), .PIPE_DLY(3))
    u_b (.sys_clk(sys_clk), .sys_rst(sys_rst), .vga(if_b));
  vga_timing_gen #(.CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                   .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                   .SYNC_POL(1'b1), .PIPE_DLY(2))
    u_c (.sys_clk(sys_clk), .sys_rst(sys_rst), .vga(if_c));
  vga_timing_gen u_d (.sys_clk(sys_clk), .sys_rst(sys_rst), .vga(if_d));

`ifdef VGA_FRAME_CNT_EN
  wire [15:0] fc_a = if_a.frame_cnt;
  wire [15:0] fc_b = if_b.frame_cnt;
  wire [15:0] fc_c = if_c.frame_cnt;
  wire [15:0] fc_d = if_d.frame_cnt;
`else
  wire [15:0] fc_a = 16'h0;
  wire [15:0] fc_b = 16'h0;
  wire [15:0] fc_c = 16'h0;
  wire [15:0] fc_d = 16'h0;
`endif

  obs_t got_a, got_b, got_c, got_d;
  assign got_a = {if_a.pixel_tick, if_a.x, if_a.y, if_a.video_on, if_a.hsync, if_a.vsync,
                  if_a.line_start, if_a.frame_start, fc_a};
  assign got_b = {if_b.pixel_tick, if_b.x, if_b.y, if_b.video_on, if_b.hsync, if_b.vsync,
                  if_b.line_start, if_b.frame_start, fc_b};
  assign got_c = {if_c.pixel_tick, if_c.x, if_c.y, if_c.video_on, if_c.hsync, if_c.vsync,
                  if_c.line_start, if_c.frame_start, fc_c};
  assign got_d = {if_d.pixel_tick, if_d.x, if_d.y, if_d.video_on, if_d.hsync, if_d.vsync,
                  if_d.line_start, if_d.frame_start, fc_d};

  // Expected outputs after the kk-th edge since reset (kk=0 means reset was sampled)
  function automatic obs_t model(input int kk, input int d, input int ht, input int vt,
                                 input int hd, input int vd, input int hs0, input int hs1,
                                 input int vs0, input int vs1, input int p, input logic pol);
    obs_t o;
    int   n, ns, hx, vy;
    o      = '0;
    n      = (kk >= 1) ? (kk - 1) / d : 0;
    o.tick = (kk >= 1) && (kk % d == 0);
    o.x    = 10'(n % ht);
    o.y    = 10'((n / ht) % vt);
    o.vid  = (kk >= 1) && (n % ht < hd) && ((n / ht) % vt < vd);
    o.ls   = (kk >= 1) && ((kk - 1) % d == 0) && (n > 0) && (n % ht == 0);
    o.fs   = o.ls && ((n / ht) % vt == 0);
    ns     = n - p;
    hx     = (ns >= 0) ? ns % ht : -1;
    vy     = (ns >= 0) ? (ns / ht) % vt : -1;
    o.hs   = (hx >= hs0 && hx < hs1) ? pol : ~pol;
    o.vs   = (vy >= vs0 && vy < vs1) ? pol : ~pol;
`ifdef VGA_FRAME_CNT_EN
    o.fc   = 16'(n / (ht * vt));
`endif
    return o;
  endfunction

  // Advance one edge, push expectations for the selected instances, settle on negedge
  task automatic cycle(input logic [3:0] mask);
    @(posedge sys_clk);
    if (sys_rst) k = 0;
    else k++;
    if (mask[0]) q_a.push_back(model(k, 4, 16, 8, 8, 4, 10, 13, 5, 7, 0, 1'b0));
    if (mask[1]) q_b.push_back(model(k, 4, 16, 8, 8, 4, 10, 13, 5, 7, 3, 1'b0));
    if (mask[2]) q_c.push_back(model(k, 1, 16, 8, 8, 4, 10, 13, 5, 7, 2, 1'b1));
    if (mask[3]) q_d.push_back(model(k, 4, 800, 525, 640, 480, 656, 752, 490, 492, 1, 1'b0));
    @(negedge sys_clk);
  endtask

  task automatic restart();
    sys_rst = 1'b1;
    cycle(4'b0000);
    cycle(4'b0000);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    sys_rst = 1'b1;
    repeat (3) begin
      cycle(4'b1111);
      e = q_a.pop_front(); n_checks++;
      if (got_a !== e) begin n_errors++; $display("FAIL reset_a got=%h exp=%h", got_a, e); end
      e = q_b.pop_front(); n_checks++;
      if (got_b !== e) begin n_errors++; $display("FAIL reset_b got=%h exp=%h", got_b, e); end
      e = q_c.pop_front(); n_checks++;
      if (got_c !== e) begin n_errors++; $display("FAIL reset_c got=%h exp=%h", got_c, e); end
      e = q_d.pop_front(); n_checks++;
      if (got_d !== e) begin n_errors++; $display("FAIL reset_d got=%h exp=%h", got_d, e); end
    end
  endtask

  task automatic test_counting();
    obs_t e;
    int vid_cyc = 0, fs1 = 0, fs2 = 0;
    restart();
    for (int i = 0; i < 1100; i++) begin
      cycle(4'b0001);
      e = q_a.pop_front(); n_checks++;
      if (got_a !== e) begin
        n_errors++;
        $display("FAIL counting k=%0d got=%h exp=%h", k, got_a, e);
      end
      if (k <= 512 && got_a.vid) vid_cyc++;
      if (got_a.fs) begin
        if (fs1 == 0) fs1 = k;
        else if (fs2 == 0) fs2 = k;
      end
    end
    n_checks++;
    if (vid_cyc !== 128) begin n_errors++; $display("FAIL video_on_cycles got=%0d exp=128", vid_cyc); end
    n_checks++;
    if (fs1 !== 513) begin n_errors++; $display("FAIL first_frame_start got=%0d exp=513", fs1); end
    n_checks++;
    if (fs2 - fs1 !== 512) begin n_errors++; $display("FAIL frame_period got=%0d exp=512", fs2 - fs1); end
`ifdef VGA_FRAME_CNT_EN
    n_checks++;
    if (got_a.fc !== 16'd2) begin n_errors++; $display("FAIL frame_cnt got=%0d exp=2", got_a.fc); end
`endif
  endtask

  task automatic test_pipe_dly();
    obs_t e;
    int   k_x = 0, k_f = 0;
    logic [9:0] prev_x = '0;
    logic prev_hs = 1'b1;
    restart();
    for (int i = 0; i < 700; i++) begin
      cycle(4'b0010);
      e = q_b.pop_front(); n_checks++;
      if (got_b !== e) begin
        n_errors++;
        $display("FAIL pipe_dly k=%0d got=%h exp=%h", k, got_b, e);
      end
      if (k_x == 0 && got_b.x == 10'd10 && prev_x != 10'd10) k_x = k;
      if (k_f == 0 && prev_hs && !got_b.hs) k_f = k;
      prev_x  = got_b.x;
      prev_hs = got_b.hs;
    end
    n_checks++;
    if (k_x == 0 || k_f - k_x !== 12) begin
      n_errors++;
      $display("FAIL hsync_lag got=%0d exp=12", k_f - k_x);
    end
  endtask

  task automatic test_clk_div1();
    obs_t e;
    int ticks = 0, ls1 = 0, ls2 = 0;
    restart();
    for (int i = 0; i < 300; i++) begin
      cycle(4'b0100);
      e = q_c.pop_front(); n_checks++;
      if (got_c !== e) begin
        n_errors++;
        $display("FAIL clk_div1 k=%0d got=%h exp=%h", k, got_c, e);
      end
      if (got_c.tick) ticks++;
      if (got_c.ls) begin
        if (ls1 == 0) ls1 = k;
        else if (ls2 == 0) ls2 = k;
      end
    end
    n_checks++;
    if (ticks !== 300) begin n_errors++; $display("FAIL tick_always got=%0d exp=300", ticks); end
    n_checks++;
    if (ls1 !== 17 || ls2 - ls1 !== 16) begin
      n_errors++;
      $display("FAIL line_period got=%0d/%0d exp=17/16", ls1, ls2 - ls1);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    int   found = 0, fs_cnt = 0, guard = 0;
    restart();
    while (!found && guard < 600) begin
      cycle(4'b0001);
      guard++;
      e = q_a.pop_front(); n_checks++;
      if (got_a !== e) begin n_errors++; $display("FAIL mid_pre k=%0d got=%h exp=%h", k, got_a, e); end
      if (got_a.x == 10'd5 && got_a.y == 10'd2) found = 1;
    end
    n_checks++;
    if (!found) begin n_errors++; $display("FAIL mid_reach got=0 exp=1"); end
    sys_rst = 1'b1;
    cycle(4'b0001);
    e = q_a.pop_front(); n_checks++;
    if (got_a !== e) begin n_errors++; $display("FAIL mid_reset got=%h exp=%h", got_a, e); end
    n_checks++;
    if (got_a.x !== 10'd0 || got_a.y !== 10'd0 || got_a.hs !== 1'b1 || got_a.vs !== 1'b1 ||
        got_a.vid !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_vals got x=%0d y=%0d hs=%b vs=%b vid=%b exp 0 0 1 1 0",
               got_a.x, got_a.y, got_a.hs, got_a.vs, got_a.vid);
    end
    sys_rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle(4'b0001);
      e = q_a.pop_front(); n_checks++;
      if (got_a !== e) begin n_errors++; $display("FAIL mid_post k=%0d got=%h exp=%h", k, got_a, e); end
      if (got_a.fs) fs_cnt++;
    end
    n_checks++;
    if (fs_cnt !== 0) begin n_errors++; $display("FAIL mid_no_frame_start got=%0d exp=0", fs_cnt); end
  endtask

  task automatic test_defaults();
    obs_t e;
    int k_y1 = 0, max_x = 0, hs_low = 0;
    restart();
    for (int i = 0; i < 3400; i++) begin
      cycle(4'b1000);
      e = q_d.pop_front(); n_checks++;
      if (got_d !== e) begin
        n_errors++;
        $display("FAIL defaults k=%0d got=%h exp=%h", k, got_d, e);
      end
      if (k_y1 == 0 && got_d.y == 10'd1) k_y1 = k;
      if (int'(got_d.x) > max_x) max_x = int'(got_d.x);
      if (k <= 3200 && !got_d.hs) hs_low++;
    end
    n_checks++;
    if (k_y1 !== 3201) begin n_errors++; $display("FAIL line_length got=%0d exp=3201", k_y1); end
    n_checks++;
    if (max_x !== 799) begin n_errors++; $display("FAIL x_max got=%0d exp=799", max_x); end
    n_checks++;
    if (hs_low !== 384) begin n_errors++; $display("FAIL hsync_width got=%0d exp=384", hs_low); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog k=%0d", k);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_counting();
    test_pipe_dly();
    test_clk_div1();
    test_reset_mid();
    test_defaults();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
